// File: rtl/fetch_unit_if.sv
// fetch_unit_if: control, instruction-memory and result signals of the fetch stage.
// The master modport is the fetch unit's side of the bus; the slave modport is its environment.
interface fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              fetch_start;
    logic [ADDR_W-1:0] pc_addr;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic [ADDR_W-1:0] pc_plus4;
    logic              fetch_busy;
    logic              fault_misaligned;
    logic              fault_timeout;

    modport master (
        input  fetch_start, pc_addr, imem_ack, imem_rdata,
        output imem_req, imem_addr, instr, instr_valid, pc_plus4,
               fetch_busy, fault_misaligned, fault_timeout
    );

    modport slave (
        output fetch_start, pc_addr, imem_ack, imem_rdata,
        input  imem_req, imem_addr, instr, instr_valid, pc_plus4,
               fetch_busy, fault_misaligned, fault_timeout
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: latches the PC, runs one req/ack fetch, captures the instruction register.
// Define FETCH_TIMEOUT_EN to abort a REQ after TIMEOUT_CYCLES ack-less cycles.
module fetch_unit #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [DATA_W-1:0] NOP = DATA_W'(32'h0000_0013);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] pc4_q, pc4_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              mis_q, mis_d;

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_q, to_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            pc4_q   <= '0;
            instr_q <= NOP;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pc4_q   <= pc4_d;
            instr_q <= instr_d;
            mis_q   <= mis_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pc4_d   = pc4_q;
        instr_d = instr_q;
        mis_d   = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        cnt_d   = cnt_q;
        to_d    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.fetch_start) begin
                    if (bus.pc_addr[1:0] == 2'b00) begin
                        addr_d  = bus.pc_addr;
                        pc4_d   = bus.pc_addr + ADDR_W'(4);
                        state_d = REQ;
`ifdef FETCH_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        mis_d = 1'b1;
                    end
                end
            end
            REQ: begin
                if (bus.imem_ack) begin
                    instr_d = bus.imem_rdata;
                    state_d = DONE;
                end
`ifdef FETCH_TIMEOUT_EN
                // cnt_q counts ack-less REQ cycles already completed
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    to_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.imem_req         = (state_q == REQ);
    assign bus.imem_addr        = addr_q;
    assign bus.instr            = instr_q;
    assign bus.instr_valid      = (state_q == DONE);
    assign bus.pc_plus4         = pc4_q;
    assign bus.fetch_busy       = (state_q != IDLE);
    assign bus.fault_misaligned = mis_q;
`ifdef FETCH_TIMEOUT_EN
    assign bus.fault_timeout    = to_q;
`else
    assign bus.fault_timeout    = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed fetch sequences with a scoreboard of expected instruction captures.
// Build with FETCH_TIMEOUT_EN defined to exercise the timeout path (TIMEOUT_CYCLES=4).
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] sb[$];
    logic [31:0] last_instr;

`ifdef FETCH_TIMEOUT_EN
    localparam int DLY = 3;
`else
    localparam int DLY = 5;
`endif

    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) b ();

    fetch_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (b.instr_valid === 1'b1) begin
            if (sb.size() == 0) chk("sb_unexpected_valid", 32'(b.instr_valid), 32'd0);
            else chk("sb_instr", b.instr, sb.pop_front());
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"}, 32'(b.imem_req), 32'd0);
        chk({tag, "_addr"}, b.imem_addr, 32'h0);
        chk({tag, "_instr"}, b.instr, 32'h0000_0013);
        chk({tag, "_valid"}, 32'(b.instr_valid), 32'd0);
        chk({tag, "_pc4"}, b.pc_plus4, 32'h0);
        chk({tag, "_busy"}, 32'(b.fetch_busy), 32'd0);
        chk({tag, "_fmis"}, 32'(b.fault_misaligned), 32'd0);
        chk({tag, "_fto"}, 32'(b.fault_timeout), 32'd0);
    endtask

    initial begin
        b.fetch_start = 1'b0;
        b.pc_addr     = '0;
        b.imem_ack    = 1'b0;
        b.imem_rdata  = '0;
        tick();
        tick();
        rst = 1'b0;
        chk_reset("reset");

        // misaligned start: pulse only, no request
        b.pc_addr = 32'h0000_0102; b.fetch_start = 1'b1;
        tick();
        b.fetch_start = 1'b0;
        chk("mis_pulse", 32'(b.fault_misaligned), 32'd1);
        chk("mis_req", 32'(b.imem_req), 32'd0);
        chk("mis_busy", 32'(b.fetch_busy), 32'd0);
        tick();
        chk("mis_pulse_end", 32'(b.fault_misaligned), 32'd0);
        chk("mis_req2", 32'(b.imem_req), 32'd0);
        chk("mis_instr", b.instr, 32'h0000_0013);
        chk("mis_addr", b.imem_addr, 32'h0);

        // basic fetch, ack in first REQ cycle
        b.pc_addr = 32'h0000_0100; b.fetch_start = 1'b1;
        tick();
        b.fetch_start = 1'b0;
        chk("f1_req", 32'(b.imem_req), 32'd1);
        chk("f1_addr", b.imem_addr, 32'h100);
        chk("f1_pc4", b.pc_plus4, 32'h104);
        chk("f1_busy", 32'(b.fetch_busy), 32'd1);
        chk("f1_valid_early", 32'(b.instr_valid), 32'd0);
        b.imem_ack = 1'b1; b.imem_rdata = 32'h0050_0093; sb.push_back(32'h0050_0093);
        tick();
        b.imem_ack = 1'b0;
        chk("f1_valid", 32'(b.instr_valid), 32'd1);
        chk("f1_instr", b.instr, 32'h0050_0093);
        chk("f1_req_done", 32'(b.imem_req), 32'd0);
        chk("f1_busy_done", 32'(b.fetch_busy), 32'd1);
        tick();
        chk("f1_valid_end", 32'(b.instr_valid), 32'd0);
        chk("f1_idle", 32'(b.fetch_busy), 32'd0);

        // delayed ack with extra starts during REQ and stray acks afterwards
        b.pc_addr = 32'h0000_0200; b.fetch_start = 1'b1;
        tick();
        for (int i = 0; i < DLY; i++) begin
            b.fetch_start = (i == 1 || i == 3);
            b.pc_addr     = 32'h0000_0300;
            chk("dly_req", 32'(b.imem_req), 32'd1);
            chk("dly_addr", b.imem_addr, 32'h200);
            chk("dly_valid", 32'(b.instr_valid), 32'd0);
            tick();
        end
        b.fetch_start = 1'b0;
        chk("dly_addr_last", b.imem_addr, 32'h200);
        b.imem_ack = 1'b1; b.imem_rdata = 32'hCAFE_0513; sb.push_back(32'hCAFE_0513);
        tick();
        b.imem_rdata = 32'h1111_1111;
        chk("dly_valid_pulse", 32'(b.instr_valid), 32'd1);
        chk("dly_instr", b.instr, 32'hCAFE_0513);
        tick();
        chk("dly_stray_idle_req", 32'(b.imem_req), 32'd0);
        chk("dly_stray_idle_busy", 32'(b.fetch_busy), 32'd0);
        tick();
        b.imem_ack = 1'b0;
        chk("dly_instr_kept", b.instr, 32'hCAFE_0513);
        chk("dly_addr_kept", b.imem_addr, 32'h200);
        chk("dly_pc4", b.pc_plus4, 32'h204);

        // PC+4 wraparound
        b.pc_addr = 32'hFFFF_FFFC; b.fetch_start = 1'b1;
        tick();
        b.fetch_start = 1'b0;
        chk("wrap_addr", b.imem_addr, 32'hFFFF_FFFC);
        chk("wrap_pc4", b.pc_plus4, 32'h0);
        b.imem_ack = 1'b1; b.imem_rdata = 32'h0000_0073; sb.push_back(32'h0000_0073);
        tick();
        b.imem_ack = 1'b0;
        chk("wrap_valid", 32'(b.instr_valid), 32'd1);
        tick();
        last_instr = 32'h0000_0073;

`ifdef FETCH_TIMEOUT_EN
        // four ack-less REQ cycles abort the fetch
        b.pc_addr = 32'h0000_0400; b.fetch_start = 1'b1;
        tick();
        b.fetch_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("to_req", 32'(b.imem_req), 32'd1);
            chk("to_nofault", 32'(b.fault_timeout), 32'd0);
            tick();
        end
        chk("to_pulse", 32'(b.fault_timeout), 32'd1);
        chk("to_req_low", 32'(b.imem_req), 32'd0);
        chk("to_busy", 32'(b.fetch_busy), 32'd0);
        chk("to_valid", 32'(b.instr_valid), 32'd0);
        chk("to_instr", b.instr, last_instr);
        tick();
        chk("to_pulse_end", 32'(b.fault_timeout), 32'd0);
`else
        // without timeout the request waits indefinitely
        b.pc_addr = 32'h0000_0400; b.fetch_start = 1'b1;
        tick();
        b.fetch_start = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("wait_req", 32'(b.imem_req), 32'd1);
        chk("wait_fto", 32'(b.fault_timeout), 32'd0);
        b.imem_ack = 1'b1; b.imem_rdata = 32'h0040_0113; sb.push_back(32'h0040_0113);
        tick();
        b.imem_ack = 1'b0;
        chk("wait_valid", 32'(b.instr_valid), 32'd1);
        tick();
`endif

        // reset in 2nd REQ cycle with a coincident ack
        b.pc_addr = 32'h0000_0500; b.fetch_start = 1'b1;
        tick();
        b.fetch_start = 1'b0;
        tick();
        chk("rst_mid_req", 32'(b.imem_req), 32'd1);
        rst = 1'b1; b.imem_ack = 1'b1; b.imem_rdata = 32'h0BAD_0BAD;
        tick();
        rst = 1'b0; b.imem_ack = 1'b0;
        chk_reset("midrst");
        tick();
        chk("midrst_valid2", 32'(b.instr_valid), 32'd0);
        chk("midrst_instr2", b.instr, 32'h0000_0013);

        chk("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
